// File: rtl/packer_stream_arbiter.sv
// rtl/packer_stream_arbiter.sv - round-robin packet arbiter that feeds one shared data_packer
module packer_stream_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          DATA_WIDTH  = 8,
    parameter int          CFG_SETTLE  = 2,
    parameter logic [15:0] CFG_DEFAULT = 16'h0410,
    localparam int         SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_wr_en,
    input  logic [SEL_W-1:0]              cfg_wr_sel,
    input  logic [15:0]                   cfg_wr_data,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [15:0]                   confi,
    output logic [SEL_W-1:0]              grant_id,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FORWARD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [15:0]             cfg_table [NUM_SRC];
    logic [DATA_WIDTH-1:0]   src_data  [NUM_SRC];
    logic [3:0]              settle_cnt;
    logic [SEL_W-1:0]        rr_ptr;
    logic [SEL_W-1:0]        rr_next;
    logic [SEL_W-1:0]        winner;
    logic [SEL_W-1:0]        scan_idx;
    logic                    any_req;
    logic                    cfg_sel_ok;
    logic                    xfer_last;
    logic [15:0]             winner_cfg;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
        assign src_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            scan_idx = SEL_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (s_axis_tvalid[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    assign cfg_sel_ok = (int'(cfg_wr_sel) < NUM_SRC);
    // A same-cycle write to the winner's entry must be what the packer sees.
    assign winner_cfg = (cfg_wr_en && cfg_sel_ok && (cfg_wr_sel == winner)) ?
                        cfg_wr_data : cfg_table[winner];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cfg_table[i] <= CFG_DEFAULT;
            end
        end else if (cfg_wr_en && cfg_sel_ok) begin
            cfg_table[cfg_wr_sel] <= cfg_wr_data;
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == FORWARD) begin
            m_axis_tdata            = src_data[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tlast            = s_axis_tlast[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
        end
    end

    assign xfer_last = (state == FORWARD) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign rr_next   = (grant_id == SEL_W'(NUM_SRC - 1)) ? '0 : grant_id + SEL_W'(1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   if (settle_cnt == 4'd1) state_nxt = FORWARD;
            FORWARD: if (xfer_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            confi      <= CFG_DEFAULT;
            settle_cnt <= '0;
            rr_ptr     <= '0;
            pkt_count  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id   <= winner;
                        confi      <= winner_cfg;
                        settle_cnt <= 4'(CFG_SETTLE);
                    end
                end
                SETUP: settle_cnt <= settle_cnt - 4'd1;
                FORWARD: begin
                    if (xfer_last) begin
                        pkt_count <= pkt_count + 16'd1;
                        rr_ptr    <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
